// File: rtl/w_mem_access_sched_pkg.sv
// Shared constants and types for the weight-memory access scheduler.
// Mode encodings match the memory wrapper's layer-mode input.
package w_mem_access_sched_pkg;

  localparam logic [2:0] MODE_CNN = 3'd0;
  localparam logic [2:0] MODE_FC  = 3'd1;
  localparam logic [2:0] MODE_ACT = 3'd2;
  localparam logic [2:0] MODE_EWS = 3'd3;

  localparam int N_DIM_ARRAY    = 8;
  localparam int STARVE_LIM_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } sched_state_e;

endpackage

// File: rtl/w_mem_access_sched_addr_gen.sv
// Read-stream address generator: base + k*stride (wrapping), issue count and
// a last flag that is high while the final read of the stream is pending.
module w_mem_addr_gen #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              adv_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o,
  output logic [LEN_W-1:0]  count_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [LEN_W-1:0]  count_q, count_d;

  always_comb begin
    addr_d   = addr_q;
    stride_d = stride_q;
    remain_d = remain_q;
    count_d  = count_q;
    if (load_i) begin
      addr_d   = base_i;
      stride_d = stride_i;
      remain_d = len_i;
      count_d  = '0;
    end else if (adv_i) begin
      // Plain modular add: address wrap past 2^ADDR_W is intended.
      addr_d   = addr_q + stride_q;
      remain_d = remain_q - LEN_W'(1);
      count_d  = count_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q   <= '0;
      stride_q <= '0;
      remain_q <= '0;
      count_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      stride_q <= stride_d;
      remain_q <= remain_d;
      count_q  <= count_d;
    end
  end

  assign addr_o  = addr_q;
  assign last_o  = (remain_q == LEN_W'(1));
  assign count_o = count_q;

endmodule

// File: rtl/w_mem_access_sched.sv
// Weight-memory access scheduler: streams configured reads and interleaves
// loader writes so that the memory never sees a read and a write together.
// Load handshake: a write is accepted on any cycle where ld_valid_i and
// ld_ready_o are both 1; ld_ready_o never depends on ld_valid_i.
module w_mem_access_sched
  import w_mem_access_sched_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int LEN_W      = 16,
  parameter int LD_DATA_W  = 128,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           mode_i,
  input  logic                 cfg_start_i,
  input  logic [ADDR_W-1:0]    cfg_base_i,
  input  logic [ADDR_W-1:0]    cfg_stride_i,
  input  logic [LEN_W-1:0]     cfg_len_i,
  input  logic                 rd_ready_i,
  output logic                 busy_o,
  output logic                 done_o,
  input  logic                 ld_valid_i,
  input  logic                 ld_fc_i,
  input  logic [ADDR_W-1:0]    ld_addr_i,
  input  logic [LD_DATA_W-1:0] ld_data_i,
  output logic                 ld_ready_o,
  output logic [2:0]           mem_mode_o,
  output logic                 mem_rd_enable_o,
  output logic [ADDR_W-1:0]    mem_rd_addr_o,
  output logic                 mem_wr_enable_cnn_o,
  output logic                 mem_wr_enable_fc_o,
  output logic [ADDR_W-1:0]    mem_wr_addr_o,
  output logic [LD_DATA_W-1:0] mem_wr_data_o,
  output logic                 rd_data_valid_o,
  output logic [1:0]           dbg_state_o,
  output logic [LEN_W-1:0]     dbg_issue_cnt_o
);

  localparam int SW = $clog2(STARVE_LIM + 1);

  sched_state_e state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [2:0] mode_q;
  logic busy_q, done_q, rd_en_q, rd_valid_q, wr_cnn_q, wr_fc_q;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
  logic [LD_DATA_W-1:0] wr_data_q;

  logic start_ok, in_stream, force_slot, issue, hs, gen_last;
  logic [ADDR_W-1:0] gen_addr;

  assign start_ok   = (state_q == ST_IDLE) && cfg_start_i;
  assign in_stream  = (state_q == ST_STREAM);
  // A full starvation counter steals this cycle from the read stream.
  assign force_slot = in_stream && (starve_q == SW'(STARVE_LIM));
  assign issue      = in_stream && rd_ready_i && !force_slot;
  assign ld_ready_o = in_stream ? (!rd_ready_i || force_slot) : 1'b1;
  assign hs         = ld_valid_i && ld_ready_o;

  w_mem_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .load_i  (start_ok),
    .base_i  (cfg_base_i),
    .stride_i(cfg_stride_i),
    .len_i   (cfg_len_i),
    .adv_i   (issue),
    .addr_o  (gen_addr),
    .last_o  (gen_last),
    .count_o (dbg_issue_cnt_o)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cfg_start_i) state_d = (cfg_len_i == '0) ? ST_DONE : ST_STREAM;
      ST_STREAM: if (issue && gen_last) state_d = ST_DRAIN;
      ST_DRAIN:  state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (hs || !ld_valid_i) starve_d = '0;
    else if (issue)        starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      starve_q   <= '0;
      mode_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_cnn_q   <= 1'b0;
      wr_fc_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      busy_q     <= (state_d == ST_STREAM) || (state_d == ST_DRAIN);
      done_q     <= (state_q == ST_DONE);
      rd_en_q    <= issue;
      rd_valid_q <= rd_en_q;
      wr_cnn_q   <= hs && !ld_fc_i;
      wr_fc_q    <= hs && ld_fc_i;
      if (start_ok) mode_q <= mode_i;
      if (issue) rd_addr_q <= gen_addr;
      if (hs) begin
        wr_addr_q <= ld_addr_i;
        wr_data_q <= ld_data_i;
      end
    end
  end

  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign mem_mode_o          = mode_q;
  assign mem_rd_enable_o     = rd_en_q;
  assign mem_rd_addr_o       = rd_addr_q;
  assign rd_data_valid_o     = rd_valid_q;
  assign mem_wr_enable_cnn_o = wr_cnn_q;
  assign mem_wr_enable_fc_o  = wr_fc_q;
  assign mem_wr_addr_o       = wr_addr_q;
  assign mem_wr_data_o       = wr_data_q;
  assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_w_mem_access_sched.sv
// Self-checking bench for w_mem_access_sched: directed scenarios plus random
// traffic, compared every cycle against a queue/counter model of the scheduler.
module tb_w_mem_access_sched;
  import w_mem_access_sched_pkg::*;

  localparam int AW = 16;
  localparam int LW = 16;
  localparam int DW = 128;
  localparam int SL = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0]    mode_i;
  logic          cfg_start_i;
  logic [AW-1:0] cfg_base_i, cfg_stride_i;
  logic [LW-1:0] cfg_len_i;
  logic          rd_ready_i;
  logic          ld_valid_i, ld_fc_i;
  logic [AW-1:0] ld_addr_i;
  logic [DW-1:0] ld_data_i;
  logic          busy_o, done_o, ld_ready_o, mem_rd_enable_o, rd_data_valid_o;
  logic          mem_wr_enable_cnn_o, mem_wr_enable_fc_o;
  logic [2:0]    mem_mode_o;
  logic [AW-1:0] mem_rd_addr_o, mem_wr_addr_o;
  logic [DW-1:0] mem_wr_data_o;
  logic [1:0]    dbg_state_o;
  logic [LW-1:0] dbg_issue_cnt_o;

  w_mem_access_sched #(.ADDR_W(AW), .LEN_W(LW), .LD_DATA_W(DW), .STARVE_LIM(SL)) dut (
    .clk(clk), .reset(reset), .mode_i(mode_i), .cfg_start_i(cfg_start_i),
    .cfg_base_i(cfg_base_i), .cfg_stride_i(cfg_stride_i), .cfg_len_i(cfg_len_i),
    .rd_ready_i(rd_ready_i), .busy_o(busy_o), .done_o(done_o),
    .ld_valid_i(ld_valid_i), .ld_fc_i(ld_fc_i), .ld_addr_i(ld_addr_i),
    .ld_data_i(ld_data_i), .ld_ready_o(ld_ready_o), .mem_mode_o(mem_mode_o),
    .mem_rd_enable_o(mem_rd_enable_o), .mem_rd_addr_o(mem_rd_addr_o),
    .mem_wr_enable_cnn_o(mem_wr_enable_cnn_o), .mem_wr_enable_fc_o(mem_wr_enable_fc_o),
    .mem_wr_addr_o(mem_wr_addr_o), .mem_wr_data_o(mem_wr_data_o),
    .rd_data_valid_o(rd_data_valid_o), .dbg_state_o(dbg_state_o),
    .dbg_issue_cnt_o(dbg_issue_cnt_o)
  );

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Stream = "reads left to issue"; the tail after the last issue is a
  // countdown: 2 = drain cycle, 1 = done cycle, done_o shows one cycle later.
  int m_left, m_k, m_cd, m_starve;
  logic [AW-1:0] m_base, m_stride;
  logic [2:0] m_mode;
  logic e_busy, e_done, e_rd_en, e_valid, e_wr_cnn, e_wr_fc;
  logic [AW-1:0] e_rd_addr, e_wr_addr;
  logic [DW-1:0] e_wr_data;
  logic t_idle, t_force, t_issue, t_ldr, t_hs;

  always @(posedge clk) begin
    if (!reset) begin
      m_left = 0; m_k = 0; m_cd = 0; m_starve = 0;
      m_base = '0; m_stride = '0; m_mode = '0;
      e_busy = 0; e_done = 0; e_rd_en = 0; e_valid = 0; e_wr_cnn = 0; e_wr_fc = 0;
      e_rd_addr = '0; e_wr_addr = '0; e_wr_data = '0;
    end else begin
      t_idle  = (m_left == 0) && (m_cd == 0);
      t_force = (m_left > 0) && (m_starve == SL);
      t_issue = (m_left > 0) && rd_ready_i && !t_force;
      t_ldr   = (m_left > 0) ? (!rd_ready_i || t_force) : 1'b1;
      t_hs    = ld_valid_i && t_ldr;
      e_valid = e_rd_en;
      e_done  = (m_cd == 1);
      if (m_cd > 0) m_cd--;
      e_rd_en = t_issue;
      if (t_issue) begin
        e_rd_addr = m_base + 16'(m_k) * m_stride;
        m_k++;
        m_left--;
        if (m_left == 0) m_cd = 2;
      end
      e_wr_cnn = t_hs && !ld_fc_i;
      e_wr_fc  = t_hs && ld_fc_i;
      if (t_hs) begin
        e_wr_addr = ld_addr_i;
        e_wr_data = ld_data_i;
      end
      if (t_hs || !ld_valid_i) m_starve = 0;
      else if (t_issue)        m_starve++;
      if (t_idle && cfg_start_i) begin
        m_mode = mode_i; m_base = cfg_base_i; m_stride = cfg_stride_i;
        m_k = 0; m_left = int'(cfg_len_i);
        if (m_left == 0) m_cd = 1;
      end
      e_busy = (m_left > 0) || (m_cd == 2);
    end
  end

  // ---------------- compare process + activity logs ----------------
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] wr_addr_log[$];
  logic [DW-1:0] wr_data_log[$];
  logic          wr_fc_log[$];
  int rd_cnt, wr_cnt, done_cnt, first_wr_reads;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 128'(busy_o), 128'(e_busy));
      chk("done", 128'(done_o), 128'(e_done));
      chk("mode", 128'(mem_mode_o), 128'(m_mode));
      chk("rd_en", 128'(mem_rd_enable_o), 128'(e_rd_en));
      if (e_rd_en) chk("rd_addr", 128'(mem_rd_addr_o), 128'(e_rd_addr));
      chk("rd_valid", 128'(rd_data_valid_o), 128'(e_valid));
      chk("wr_cnn", 128'(mem_wr_enable_cnn_o), 128'(e_wr_cnn));
      chk("wr_fc", 128'(mem_wr_enable_fc_o), 128'(e_wr_fc));
      if (e_wr_cnn || e_wr_fc) begin
        chk("wr_addr", 128'(mem_wr_addr_o), 128'(e_wr_addr));
        chk("wr_data", mem_wr_data_o, e_wr_data);
      end
      chk("ld_ready", 128'(ld_ready_o),
          128'((m_left > 0) ? (!rd_ready_i || m_starve == SL) : 1'b1));
      chk("state", 128'(dbg_state_o),
          128'((m_left > 0) ? 1 : (m_cd == 2) ? 2 : (m_cd == 1) ? 3 : 0));
      chk("issue_cnt", 128'(dbg_issue_cnt_o), 128'(m_k));
      chk("rd_wr_overlap", 128'(mem_rd_enable_o && (mem_wr_enable_cnn_o || mem_wr_enable_fc_o)), 128'(0));
      chk("dual_wr", 128'(mem_wr_enable_cnn_o && mem_wr_enable_fc_o), 128'(0));
      if (mem_rd_enable_o) begin
        rd_log.push_back(mem_rd_addr_o);
        rd_cnt++;
      end
      if (mem_wr_enable_cnn_o || mem_wr_enable_fc_o) begin
        wr_addr_log.push_back(mem_wr_addr_o);
        wr_data_log.push_back(mem_wr_data_o);
        wr_fc_log.push_back(mem_wr_enable_fc_o);
        if (wr_cnt == 0) first_wr_reads = rd_cnt;
        wr_cnt++;
      end
      if (done_o) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete(); wr_fc_log.delete();
    exp_q.delete();
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; first_wr_reads = -1;
  endtask

  task automatic start(input logic [2:0] m, input logic [AW-1:0] b, input logic [AW-1:0] s,
                       input logic [LW-1:0] l);
    mode_i = m; cfg_base_i = b; cfg_stride_i = s; cfg_len_i = l;
    cfg_start_i = 1'b1;
    tick();
    cfg_start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done_o && n < budget) begin
      tick();
      n++;
    end
    if (!done_o) chk({name, "_timeout"}, 128'(0), 128'(1));
    tick();
    tick();
  endtask

  task automatic load_one(input logic fc, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic got;
    int n;
    got = 1'b0;
    n = 0;
    ld_valid_i = 1'b1; ld_fc_i = fc; ld_addr_i = a; ld_data_i = d;
    while (!got && n < 100) begin
      #1;
      got = ld_ready_o;
      tick();
      n++;
    end
    ld_valid_i = 1'b0;
    if (!got) chk("load_timeout", 128'(0), 128'(1));
  endtask

  task automatic check_reads(input string name);
    chk({name, "_count"}, 128'(rd_log.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rd_log.size(); i++)
      chk({name, "_addr"}, 128'(rd_log[i]), 128'(exp_q[i]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; mode_i = '0; cfg_start_i = 0; cfg_base_i = '0; cfg_stride_i = '0;
    cfg_len_i = '0; rd_ready_i = 0; ld_valid_i = 0; ld_fc_i = 0; ld_addr_i = '0; ld_data_i = '0;
    clear_logs();
    repeat (3) tick();
    chk_en = 1'b1;
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_rd_en", 128'(mem_rd_enable_o), 128'(0));
    chk("rst_mode", 128'(mem_mode_o), 128'(0));
    reset = 1'b1;
    tick();

    // Basic stream
    rd_ready_i = 1'b1;
    start(MODE_CNN, 16'h0010, 16'h1, 16'd4);
    wait_done("basic", 40);
    exp_q = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
    check_reads("basic");
    chk("basic_done_once", 128'(done_cnt), 128'(1));
    clear_logs();

    // Wrap and stride
    start(MODE_FC, 16'hFFFE, 16'h3, 16'd3);
    wait_done("wrap", 40);
    exp_q = '{16'hFFFE, 16'h0001, 16'h0004};
    check_reads("wrap");
    clear_logs();

    // Starvation guard: one load pending from the first stream cycle
    start(MODE_CNN, 16'h0100, 16'h1, 16'd20);
    load_one(1'b0, 16'h0055, {4{32'hA5A5_0001}});
    wait_done("starve", 100);
    for (int i = 0; i < 20; i++) exp_q.push_back(16'h0100 + 16'(i));
    check_reads("starve");
    chk("starve_writes", 128'(wr_cnt), 128'(1));
    chk("starve_reads_before_wr", 128'(first_wr_reads), 128'(8));
    if (wr_addr_log.size() > 0) chk("starve_wr_addr", 128'(wr_addr_log[0]), 128'(16'h0055));
    clear_logs();

    // Stall grants loads
    start(MODE_FC, 16'h0200, 16'h2, 16'd6);
    tick(); tick();
    rd_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) load_one(1'b1, 16'h0030 + 16'(i), {96'h0, 32'hD0 + 32'(i)});
    rd_ready_i = 1'b1;
    wait_done("stall", 60);
    for (int i = 0; i < 6; i++) exp_q.push_back(16'h0200 + 16'(2 * i));
    check_reads("stall");
    chk("stall_writes", 128'(wr_cnt), 128'(3));
    for (int i = 0; i < 3 && i < wr_cnt; i++) begin
      chk("stall_wr_fc", 128'(wr_fc_log[i]), 128'(1));
      chk("stall_wr_addr", 128'(wr_addr_log[i]), 128'(16'h0030 + 16'(i)));
      chk("stall_wr_data", wr_data_log[i], {96'h0, 32'hD0 + 32'(i)});
    end
    clear_logs();

    // len = 0: done two cycles after start, no reads
    start(MODE_ACT, 16'h0000, 16'h1, 16'd0);
    chk("len0_done_early", 128'(done_o), 128'(0));
    tick();
    chk("len0_done", 128'(done_o), 128'(1));
    tick(); tick();
    chk("len0_reads", 128'(rd_cnt), 128'(0));
    clear_logs();

    // Start while busy is ignored
    start(MODE_CNN, 16'h0300, 16'h1, 16'd5);
    tick();
    start(MODE_EWS, 16'h0400, 16'h1, 16'd9);
    wait_done("busy_start", 60);
    for (int i = 0; i < 5; i++) exp_q.push_back(16'h0300 + 16'(i));
    check_reads("busy_start");
    chk("busy_start_mode", 128'(mem_mode_o), 128'(MODE_CNN));
    clear_logs();

    // Reset on the second issue cycle
    start(MODE_CNN, 16'h0500, 16'h1, 16'd6);
    tick();
    reset = 1'b0;
    tick();
    chk("mid_rst_busy", 128'(busy_o), 128'(0));
    chk("mid_rst_rd_en", 128'(mem_rd_enable_o), 128'(0));
    chk("mid_rst_valid", 128'(rd_data_valid_o), 128'(0));
    chk("mid_rst_state", 128'(dbg_state_o), 128'(ST_IDLE));
    reset = 1'b1;
    repeat (10) tick();
    chk("mid_rst_no_done", 128'(done_cnt), 128'(0));
    clear_logs();
    start(MODE_CNN, 16'h0010, 16'h1, 16'd4);
    wait_done("post_rst", 40);
    exp_q = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
    check_reads("post_rst");
    clear_logs();

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rd_ready_i  = ($urandom_range(0, 3) != 0);
      ld_valid_i  = ($urandom_range(0, 2) == 0);
      ld_fc_i     = $urandom_range(0, 1) == 1;
      ld_addr_i   = 16'($urandom);
      ld_data_i   = {$urandom, $urandom, $urandom, $urandom};
      cfg_start_i = ($urandom_range(0, 11) == 0);
      mode_i      = 3'($urandom_range(0, 3));
      cfg_base_i  = 16'($urandom);
      cfg_stride_i = 16'($urandom_range(0, 5));
      cfg_len_i   = 16'($urandom_range(0, 24));
      reset       = ($urandom_range(0, 599) != 0);
      tick();
    end
    reset = 1'b1; cfg_start_i = 0; ld_valid_i = 0; rd_ready_i = 1;
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
